muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_data  input  XLEN  operand A, taken from the register file read_data1.
REQ-007 rs2_data  input  XLEN  operand B, taken from the register file read_data2.
REQ-008 rd_addr  input  5  destination register index.
REQ-009 flush  input  1  abort any in-flight operation.
REQ-010 busy  output  1  high in CALC and DONE.
REQ-011 done  output  1  one-cycle result-valid pulse.
REQ-012 wb_we  output  1  register-file write enable.
REQ-013 wb_addr  output  5  register-file write index.
REQ-014 wb_data  output  XLEN  register-file write data.

Function
REQ-015 The FSM SHALL have states IDLE, CALC and DONE, with IDLE as the reset state.
REQ-016 IDLE->CALC SHALL occur on the edge where start=1; at that edge the unit captures funct3, rd_addr and both operands.
REQ-017 While busy=1, start SHALL be ignored, and no operand or command register SHALL change except the internal datapath.
REQ-018 CALC SHALL last exactly 32 cycles, using a 6-bit counter from 0 to 31, then go to DONE.
- Latency is fixed for all ops, including the special cases below.
- done rises 33 cycles after the start edge.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE.
- start is accepted again in the cycle after DONE.
REQ-020 Multiply SHALL be radix-2 shift-add on magnitudes, with the 64-bit product sign-corrected.
- Signedness per op: MULH s*s, MULHSU s*u, MULHU u*u.
- MUL returns the low 32 bits; MULH/MULHSU/MULHU return the high 32 bits.
REQ-021 Divide SHALL be restoring, one quotient bit per CALC cycle, on magnitudes.
- Quotient sign = sign(A) XOR sign(B).
- Remainder sign = sign(A) (signed ops only).
REQ-022 Divide by zero SHALL produce: DIV/DIVU quotient 0xFFFFFFFF; REM/REMU remainder = A.
REQ-023 Signed overflow (A=0x80000000, B=0xFFFFFFFF) SHALL produce: DIV 0x80000000; REM 0x00000000.
REQ-024 In DONE, done SHALL be 1 and wb_data SHALL equal the result.
- wb_addr SHALL equal the captured rd_addr.
- wb_we SHALL equal 1 only if the captured rd_addr != 0.
REQ-025 Outside DONE, done and wb_we SHALL be 0.
- wb_addr and wb_data SHALL hold their last values.
REQ-026 flush=1 in CALC or DONE SHALL force IDLE on the next edge with done=0 and wb_we=0 in that cycle, so no writeback occurs.
- flush and start together in IDLE: flush wins; the start is dropped.
REQ-027 Operand changes on rs1_data/rs2_data after the start edge SHALL NOT affect the result.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE and clear all registers, regardless of clk.
- Forced to 0: busy, done, wb_we, wb_addr, wb_data, counter, and all operand and accumulator registers.
REQ-029 Reset asserted mid-CALC SHALL discard the operation; no done pulse follows reset release.
REQ-030 After rst_n deasserts, the first start SHALL be accepted on the first posedge where start=1.

Verification
REQ-031 MUL 7 * -3 (rs2=0xFFFFFFFD), rd=5:
- done at cycle 33, wb_we=1, wb_addr=5, wb_data=0xFFFFFFEB.
- MULH on the same operands gives 0xFFFFFFFF; MULHU gives 0x00000006.
REQ-032 DIV -7 / 2 gives 0xFFFFFFFD; REM -7 % 2 gives 0xFFFFFFFF; DIVU 0xFFFFFFF9 / 2 gives 0x7FFFFFFC.
REQ-033 DIVU 100 / 0 gives 0xFFFFFFFF; REM 100 % 0 gives 100; DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000.
- All three complete in exactly 33 cycles.
REQ-034 MUL with rd=0: done=1 in DONE, but wb_we=0.
REQ-035 start pulses during CALC are ignored, with exactly one done.
REQ-036 flush at CALC cycle 10 -> IDLE next cycle, no done, no wb_we.
REQ-037 rst_n low at CALC cycle 20 -> outputs immediately 0.
- A new MUL 3*4 after release returns 0x0000000C in 33 cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-cycle multiply/divide unit with register-file writeback
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign-corrected at the end.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            wb_we,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [5:0]        cnt_q;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic              a_neg_q, b_neg_q, div0_q;
  logic [XLEN-1:0]   a_raw_q;
  logic [XLEN-1:0]   d_q;
  logic [XLEN-1:0]   acc_hi_q, acc_lo_q;

  logic              accept, last_step;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic [XLEN-1:0]   hi_step, lo_step;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, result;

  assign accept    = (state_q == S_IDLE) && start && !flush;
  assign last_step = (state_q == S_CALC) && (cnt_q == 6'(XLEN-1)) && !flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && !flush) state_d = S_CALC;
      S_CALC:  if (flush) state_d = S_IDLE;
               else if (cnt_q == 6'(XLEN-1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_DONE) && !flush;
    wb_we = done && (rd_q != 5'd0);
  end

  // MUL treats both operands as unsigned; its low half is identical either way.
  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = a_signed && rs1_data[XLEN-1];
    b_neg    = b_signed && rs2_data[XLEN-1];
    a_mag    = a_neg ? (~rs1_data + 1'b1) : rs1_data;
    b_mag    = b_neg ? (~rs2_data + 1'b1) : rs2_data;
  end

  // Multiply: acc_lo holds the multiplier, shifted out LSB-first while the product enters from the top.
  // Divide: {acc_hi, acc_lo} shifts left, acc_hi is the partial remainder, quotient bits fill acc_lo.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, d_q} : {(XLEN+1){1'b0}});
    div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, d_q};
    if (op_q[2]) begin
      hi_step = div_diff[XLEN+1] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      lo_step = {acc_lo_q[XLEN-2:0], ~div_diff[XLEN+1]};
    end else begin
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], acc_lo_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod   = {hi_step, lo_step};
    prod_s = (a_neg_q ^ b_neg_q) ? (~prod + 1'b1) : prod;
    quo_s  = (a_neg_q ^ b_neg_q) ? (~lo_step + 1'b1) : lo_step;
    rem_s  = a_neg_q ? (~hi_step + 1'b1) : hi_step;
    case (op_q)
      3'b000:         result = prod_s[XLEN-1:0];
      3'b100, 3'b101: result = div0_q ? {XLEN{1'b1}} : quo_s;
      3'b110, 3'b111: result = div0_q ? a_raw_q : rem_s;
      default:        result = prod_s[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      op_q     <= 3'd0;
      rd_q     <= 5'd0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
      a_raw_q  <= '0;
      d_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      wb_addr  <= 5'd0;
      wb_data  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q    <= 6'd0;
        op_q     <= funct3;
        rd_q     <= rd_addr;
        a_neg_q  <= a_neg;
        b_neg_q  <= b_neg;
        div0_q   <= (rs2_data == '0);
        a_raw_q  <= rs1_data;
        d_q      <= funct3[2] ? b_mag : a_mag;
        acc_hi_q <= '0;
        acc_lo_q <= funct3[2] ? a_mag : b_mag;
      end else if (state_q == S_CALC && !flush) begin
        cnt_q    <= cnt_q + 6'd1;
        acc_hi_q <= hi_step;
        acc_lo_q <= lo_step;
      end
      if (last_step) begin
        wb_data <= result;
        wb_addr <= rd_q;
      end
    end
  end

endmodule
